// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side (CPU, loader) and memory-side signals around mem_arbiter.
// The arbiter takes the slave modport; requesters and the memory model take master.
interface mem_arbiter_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned AWIDTH = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [AWIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0]  cpu_wdata;
    logic              cpu_ack;

    logic              ldr_req;
    logic              ldr_we;
    logic [AWIDTH-1:0] ldr_addr;
    logic [WIDTH-1:0]  ldr_wdata;
    logic              ldr_lock;
    logic              ldr_ack;

    logic [WIDTH-1:0]  rdata;
    logic [1:0]        gnt;
    logic              busy;

    logic              mem_en;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        input  mem_rdata,
        output cpu_ack, ldr_ack, rdata, gnt, busy,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
        output mem_rdata,
        input  cpu_ack, ldr_ack, rdata, gnt, busy,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the CPU path and the loader: round-robin grant,
// loader burst lock, fixed-latency access and a one-cycle completion ack.
module mem_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned AWIDTH  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_ldr;

    logic              pick_cpu;
    logic              pick_ldr;
    logic              sel_we;
    logic [AWIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

    // Arbitration: lock owns the port for the loader, otherwise round-robin on ties
    always_comb begin
        pick_cpu = 1'b0;
        pick_ldr = 1'b0;
        if (bus.ldr_lock) begin
            pick_ldr = bus.ldr_req;
        end else if (bus.cpu_req && bus.ldr_req) begin
            pick_ldr = !last_ldr;
            pick_cpu = last_ldr;
        end else begin
            pick_cpu = bus.cpu_req;
            pick_ldr = bus.ldr_req;
        end
        sel_we    = pick_ldr ? bus.ldr_we    : bus.cpu_we;
        sel_addr  = pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
        sel_wdata = pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            last_ldr      <= 1'b1;
            bus.cpu_ack   <= 1'b0;
            bus.ldr_ack   <= 1'b0;
            bus.rdata     <= '0;
            bus.gnt       <= 2'b00;
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_cpu || pick_ldr) begin
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= sel_we;
                        bus.gnt       <= {pick_ldr, pick_cpu};
                        bus.busy      <= 1'b1;
                        last_ldr      <= pick_ldr;
                        cnt           <= CNT_W'(MEM_LAT - 1);
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // mem_we is still the latched direction in the last access cycle
                        if (!bus.mem_we) begin
                            bus.rdata <= bus.mem_rdata;
                        end
                        bus.mem_en  <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        bus.cpu_ack <= bus.gnt[0];
                        bus.ldr_ack <= bus.gnt[1];
                        state       <= DONE;
                    end
                end
                DONE: begin
                    bus.cpu_ack <= 1'b0;
                    bus.ldr_ack <= 1'b0;
                    bus.gnt     <= 2'b00;
                    bus.busy    <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level arbitration/memory model.
module tb_mem_arbiter;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned AWIDTH = 16;
    localparam int          LAT    = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   timeout_flag = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus  ();
    mem_arbiter_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus2 ();

    mem_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    mem_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH), .MEM_LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    // Memory array behind the main DUT; unwritten words hold a fixed pattern
    function automatic logic [15:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : ({a, a} ^ 16'h3C5A);
    endfunction

    logic [15:0] mem_arr [256];
    bit          written [256];
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) begin
            mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
            written[bus.mem_addr[7:0]] <= 1'b1;
        end
    end
    assign bus.mem_rdata  = written[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]]
                                                       : init_val(bus.mem_addr[7:0]);
    assign bus2.mem_rdata = 16'h5A5A;

    // Event monitor for the main DUT
    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } grant_t;
    typedef struct {
        int          cyc;
        logic        cpu;
        logic        ldr;
        logic [15:0] rdata;
        logic [15:0] rdata_prev;
        logic        busy;
    } ack_t;

    grant_t      grant_q[$];
    ack_t        ack_q[$];
    int          en_len_q[$];
    int          en_start_q[$];
    int          en_run = 0;
    int          both_ack = 0;
    logic [1:0]  prev_gnt = 2'b00;
    logic [15:0] prev_rdata = '0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.gnt != 2'b00 && prev_gnt == 2'b00)
                grant_q.push_back('{cyc, bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata});
            if (bus.cpu_ack || bus.ldr_ack)
                ack_q.push_back('{cyc, bus.cpu_ack, bus.ldr_ack, bus.rdata, prev_rdata, bus.busy});
            if (bus.cpu_ack && bus.ldr_ack) both_ack++;
            if (bus.mem_en) begin
                if (en_run == 0) en_start_q.push_back(cyc);
                en_run++;
            end else if (en_run != 0) begin
                en_len_q.push_back(en_run);
                en_run = 0;
            end
        end else begin
            en_run = 0;
        end
        prev_gnt   = bus.gnt;
        prev_rdata = bus.rdata;
    end

    task automatic clear_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        bus.ldr_lock = 1'b0;
        bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
        bus2.ldr_req = 1'b0; bus2.ldr_we = 1'b0; bus2.ldr_addr = '0; bus2.ldr_wdata = '0;
        bus2.ldr_lock = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        grant_q.delete(); ack_q.delete(); en_len_q.delete(); en_start_q.delete();
        both_ack = 0;
        reset = 1'b0;
    endtask

    // Requester agents: hold req across n accesses, stepping address/data after each ack
    task automatic cpu_agent(input int n, input logic we, input logic [15:0] base,
                             input logic [15:0] wbase);
        int w;
        bus.cpu_we = we; bus.cpu_addr = base; bus.cpu_wdata = wbase; bus.cpu_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!bus.cpu_ack && w < 200);
            if (!bus.cpu_ack) begin timeout_flag = 1'b1; break; end
            bus.cpu_addr  = base + 16'(i + 1);
            bus.cpu_wdata = wbase + 16'(i + 1);
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic ldr_agent(input int n, input logic we, input logic [15:0] base,
                             input logic [15:0] wbase);
        int w;
        bus.ldr_we = we; bus.ldr_addr = base; bus.ldr_wdata = wbase; bus.ldr_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin @(negedge clk); w++; end while (!bus.ldr_ack && w < 200);
            if (!bus.ldr_ack) begin timeout_flag = 1'b1; break; end
            bus.ldr_addr  = base + 16'(i + 1);
            bus.ldr_wdata = wbase + 16'(i + 1);
        end
        bus.ldr_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.cpu_ack, bus.ldr_ack, bus.mem_en, bus.mem_we, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.cpu_ack, bus.ldr_ack, bus.mem_en, bus.mem_we, bus.busy});
        end
        n_checks++;
        if ({bus.gnt, bus.rdata, bus.mem_addr, bus.mem_wdata} !== 50'b0) begin
            n_fail++;
            $display("FAIL reset_data: gnt=%b rdata=%h addr=%h wdata=%h expected all 0",
                     bus.gnt, bus.rdata, bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if ({bus2.cpu_ack, bus2.ldr_ack, bus2.mem_en, bus2.mem_we, bus2.busy, bus2.gnt} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_lat1: got %b expected 0",
                     {bus2.cpu_ack, bus2.ldr_ack, bus2.mem_en, bus2.mem_we, bus2.busy, bus2.gnt});
        end
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        int t;
        do_reset();
        t = cyc;
        cpu_agent(1, 1'b0, 16'h0010, 16'h0000);
        repeat (3) @(negedge clk);
        n_checks++;
        if (en_start_q.size() != 1 || en_len_q.size() != 1) begin
            n_fail++;
            $display("FAIL rd_en_count: got %0d windows expected 1", en_start_q.size());
        end else begin
            n_checks++;
            if (en_start_q[0] != t + 1 || en_len_q[0] != LAT) begin
                n_fail++;
                $display("FAIL rd_en_window: got start %0d len %0d expected start %0d len %0d",
                         en_start_q[0], en_len_q[0], t + 1, LAT);
            end
        end
        n_checks++;
        if (ack_q.size() != 1) begin
            n_fail++;
            $display("FAIL rd_ack_count: got %0d expected 1", ack_q.size());
        end else begin
            n_checks++;
            if (ack_q[0].cyc != t + LAT + 1 || !ack_q[0].cpu || ack_q[0].ldr) begin
                n_fail++;
                $display("FAIL rd_ack: got cyc %0d cpu %b ldr %b expected cyc %0d cpu 1 ldr 0",
                         ack_q[0].cyc, ack_q[0].cpu, ack_q[0].ldr, t + LAT + 1);
            end
            n_checks++;
            if (ack_q[0].rdata !== 16'hBEEF || ack_q[0].busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_data: got rdata %h busy %b expected BEEF busy 1",
                         ack_q[0].rdata, ack_q[0].busy);
            end
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_idle: got busy %b gnt %b expected 0 00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_g;
        logic [15:0] exp_a;
        do_reset();
        fork
            cpu_agent(3, 1'b0, 16'h0040, 16'h0000);
            ldr_agent(3, 1'b0, 16'h0050, 16'h0000);
        join
        repeat (3) @(negedge clk);
        n_checks++;
        if (grant_q.size() != 6 || ack_q.size() != 6) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants %0d acks expected 6 6",
                     grant_q.size(), ack_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
                exp_a = ((i % 2 == 0) ? 16'h0040 : 16'h0050) + 16'(i / 2);
                n_checks++;
                if (grant_q[i].gnt !== exp_g || grant_q[i].addr !== exp_a) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: got gnt %b addr %h expected gnt %b addr %h",
                             i, grant_q[i].gnt, grant_q[i].addr, exp_g, exp_a);
                end
                n_checks++;
                if ({ack_q[i].ldr, ack_q[i].cpu} !== exp_g || ack_q[i].rdata !== init_val(exp_a[7:0])) begin
                    n_fail++;
                    $display("FAIL rr_ack%0d: got ack %b rdata %h expected ack %b rdata %h",
                             i, {ack_q[i].ldr, ack_q[i].cpu}, ack_q[i].rdata, exp_g,
                             init_val(exp_a[7:0]));
                end
                if (i > 0) begin
                    n_checks++;
                    if (grant_q[i].cyc - grant_q[i-1].cyc != LAT + 2) begin
                        n_fail++;
                        $display("FAIL rr_spacing%0d: got %0d expected %0d",
                                 i, grant_q[i].cyc - grant_q[i-1].cyc, LAT + 2);
                    end
                end
            end
        end
        n_checks++;
        if (both_ack != 0) begin
            n_fail++;
            $display("FAIL rr_both_ack: got %0d expected 0", both_ack);
        end
    endtask

    task automatic test_lock();
        int drop_cyc;
        do_reset();
        bus.ldr_lock = 1'b1;
        drop_cyc = 0;
        fork
            cpu_agent(1, 1'b0, 16'h0020, 16'h0000);
            begin
                ldr_agent(4, 1'b1, 16'h0000, 16'hA000);
                repeat (6) @(negedge clk);
                n_checks++;
                if (grant_q.size() != 4 || bus.gnt !== 2'b00) begin
                    n_fail++;
                    $display("FAIL lock_block: got %0d grants gnt %b expected 4 00",
                             grant_q.size(), bus.gnt);
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        n_checks++;
                        if (grant_q[i].gnt !== 2'b10 || grant_q[i].we !== 1'b1 ||
                            grant_q[i].addr !== 16'(i) || grant_q[i].wdata !== 16'hA000 + 16'(i)) begin
                            n_fail++;
                            $display("FAIL lock_wr%0d: got gnt %b we %b addr %h data %h expected 10 1 %h %h",
                                     i, grant_q[i].gnt, grant_q[i].we, grant_q[i].addr,
                                     grant_q[i].wdata, 16'(i), 16'hA000 + 16'(i));
                        end
                    end
                end
                drop_cyc = cyc;
                bus.ldr_lock = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        n_checks++;
        if (grant_q.size() != 5) begin
            n_fail++;
            $display("FAIL lock_release: got %0d grants expected 5", grant_q.size());
        end else begin
            n_checks++;
            if (grant_q[4].gnt !== 2'b01 || grant_q[4].cyc != drop_cyc + 1) begin
                n_fail++;
                $display("FAIL lock_cpu_next: got gnt %b cyc %0d expected 01 cyc %0d",
                         grant_q[4].gnt, grant_q[4].cyc, drop_cyc + 1);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        bus.cpu_we = 1'b1; bus.cpu_addr = 16'h00F0; bus.cpu_wdata = 16'hDEAD; bus.cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got en %b we %b gnt %b expected 1 1 01",
                     bus.mem_en, bus.mem_we, bus.gnt);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_en, bus.mem_we, bus.gnt, bus.cpu_ack, bus.busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_mid_post: got en/we/gnt/ack/busy %b expected 000000",
                     {bus.mem_en, bus.mem_we, bus.gnt, bus.cpu_ack, bus.busy});
        end
        bus.cpu_req = 1'b0;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_noack: got %0d acks expected 0", ack_q.size());
        end
    endtask

    task automatic test_rdata_hold();
        logic [15:0] prior;
        prior = init_val(8'h11);
        do_reset();
        cpu_agent(1, 1'b0, 16'h0011, 16'h0000);
        ldr_agent(1, 1'b1, 16'h0030, 16'h1234);
        cpu_agent(1, 1'b0, 16'h0030, 16'h0000);
        repeat (2) @(negedge clk);
        n_checks++;
        if (ack_q.size() != 3) begin
            n_fail++;
            $display("FAIL hold_count: got %0d acks expected 3", ack_q.size());
        end else begin
            n_checks++;
            if (!ack_q[1].ldr || ack_q[1].rdata !== prior || ack_q[1].rdata_prev !== prior) begin
                n_fail++;
                $display("FAIL hold_wr_ack: got ldr %b rdata %h prev %h expected 1 %h %h",
                         ack_q[1].ldr, ack_q[1].rdata, ack_q[1].rdata_prev, prior, prior);
            end
            n_checks++;
            if (!ack_q[2].cpu || ack_q[2].rdata !== 16'h1234 || ack_q[2].rdata_prev !== prior) begin
                n_fail++;
                $display("FAIL hold_rd_ack: got cpu %b rdata %h prev %h expected 1 1234 %h",
                         ack_q[2].cpu, ack_q[2].rdata, ack_q[2].rdata_prev, prior);
            end
        end
    endtask

    task automatic test_mem_lat1();
        int t, en_cnt, en_first, ack_cyc, w;
        logic [15:0] rd;
        logic ldr_seen;
        do_reset();
        en_cnt = 0; en_first = -1; ack_cyc = -1; rd = '0; ldr_seen = 1'b0;
        t = cyc;
        bus2.cpu_we = 1'b0; bus2.cpu_addr = 16'h0007; bus2.cpu_req = 1'b1;
        w = 0;
        while (w < 20) begin
            @(negedge clk);
            w++;
            if (bus2.ldr_ack) ldr_seen = 1'b1;
            if (bus2.mem_en) begin
                if (en_first < 0) en_first = cyc;
                en_cnt++;
            end
            if (bus2.cpu_ack) begin
                ack_cyc = cyc;
                rd = bus2.rdata;
                bus2.cpu_req = 1'b0;
                break;
            end
        end
        bus2.cpu_req = 1'b0;
        n_checks++;
        if (en_cnt != 1 || en_first != t + 1) begin
            n_fail++;
            $display("FAIL lat1_en: got %0d cycles from %0d expected 1 from %0d",
                     en_cnt, en_first, t + 1);
        end
        n_checks++;
        if (ack_cyc != t + 2 || rd !== 16'h5A5A || ldr_seen) begin
            n_fail++;
            $display("FAIL lat1_ack: got cyc %0d rdata %h ldr %b expected cyc %0d 5A5A 0",
                     ack_cyc, rd, ldr_seen, t + 2);
        end
    endtask

    // Reference model state for randomized rounds: memory image, last read, last owner
    logic [15:0] ref_mem [256];
    bit          ref_wr  [256];

    function automatic logic [15:0] ref_read(input logic [7:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic test_random();
        logic        m_last_ldr;
        logic [15:0] m_last_read;
        int          mask, nexp, bg, ba, be;
        logic        c_we, l_we;
        logic [15:0] c_addr, l_addr, c_wd, l_wd;
        logic        ord_ldr [2];
        logic        e_we;
        logic [15:0] e_addr, e_wd, e_rd;
        do_reset();
        m_last_ldr = 1'b1;
        m_last_read = '0;
        for (int r = 0; r < 40; r++) begin
            mask   = $urandom_range(1, 3);
            c_we   = 1'($urandom_range(0, 1));
            l_we   = 1'($urandom_range(0, 1));
            c_addr = 16'h0080 + 16'($urandom_range(0, 15));
            l_addr = 16'h0080 + 16'($urandom_range(0, 15));
            c_wd   = 16'($urandom);
            l_wd   = 16'($urandom);
            if (mask == 3) begin
                nexp = 2;
                ord_ldr[0] = !m_last_ldr;
                ord_ldr[1] = m_last_ldr;
            end else begin
                nexp = 1;
                ord_ldr[0] = (mask == 2);
                ord_ldr[1] = 1'b0;
            end
            bg = grant_q.size(); ba = ack_q.size(); be = en_len_q.size();
            fork
                begin if (mask[0]) cpu_agent(1, c_we, c_addr, c_wd); end
                begin if (mask[1]) ldr_agent(1, l_we, l_addr, l_wd); end
            join
            repeat (2) @(negedge clk);
            n_checks++;
            if (grant_q.size() != bg + nexp || ack_q.size() != ba + nexp ||
                en_len_q.size() != be + nexp) begin
                n_fail++;
                $display("FAIL rnd%0d_count: got %0d grants %0d acks expected %0d",
                         r, grant_q.size() - bg, ack_q.size() - ba, nexp);
                continue;
            end
            for (int k = 0; k < nexp; k++) begin
                e_we   = ord_ldr[k] ? l_we   : c_we;
                e_addr = ord_ldr[k] ? l_addr : c_addr;
                e_wd   = ord_ldr[k] ? l_wd   : c_wd;
                if (e_we) begin
                    ref_mem[e_addr[7:0]] = e_wd;
                    ref_wr[e_addr[7:0]]  = 1'b1;
                end else begin
                    m_last_read = ref_read(e_addr[7:0]);
                end
                e_rd = m_last_read;
                m_last_ldr = ord_ldr[k];
                n_checks++;
                if (grant_q[bg+k].gnt !== {ord_ldr[k], !ord_ldr[k]} || grant_q[bg+k].we !== e_we ||
                    grant_q[bg+k].addr !== e_addr || (e_we && grant_q[bg+k].wdata !== e_wd)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_grant%0d: got gnt %b we %b addr %h wd %h expected %b %b %h %h",
                             r, k, grant_q[bg+k].gnt, grant_q[bg+k].we, grant_q[bg+k].addr,
                             grant_q[bg+k].wdata, {ord_ldr[k], !ord_ldr[k]}, e_we, e_addr, e_wd);
                end
                n_checks++;
                if ({ack_q[ba+k].ldr, ack_q[ba+k].cpu} !== {ord_ldr[k], !ord_ldr[k]} ||
                    ack_q[ba+k].rdata !== e_rd || ack_q[ba+k].cyc != grant_q[bg+k].cyc + LAT ||
                    en_len_q[be+k] != LAT) begin
                    n_fail++;
                    $display("FAIL rnd%0d_ack%0d: got ack %b rdata %h dly %0d en %0d expected %b %h %0d %0d",
                             r, k, {ack_q[ba+k].ldr, ack_q[ba+k].cpu}, ack_q[ba+k].rdata,
                             ack_q[ba+k].cyc - grant_q[bg+k].cyc, en_len_q[be+k],
                             {ord_ldr[k], !ord_ldr[k]}, e_rd, LAT, LAT);
                end
            end
        end
        n_checks++;
        if (timeout_flag || both_ack != 0) begin
            n_fail++;
            $display("FAIL rnd_sanity: got timeout %b both_ack %0d expected 0 0",
                     timeout_flag, both_ack);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_lock();
        test_reset_mid_access();
        test_rdata_hold();
        test_mem_lat1();
        test_random();
        n_checks++;
        if (timeout_flag) begin
            n_fail++;
            $display("FAIL agent_timeout: got 1 expected 0");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
